bfm_collector: RTL
==================

Name: bfm_collector

Overview:
- Receive-side companion to the byte-streaming stimulus BFM in the harness.
- Samples the DUT's 8-bit result bus once per accepted stimulus byte and packs 32 bytes, LSB-first, into one TOTAL_WIDTH-bit vector.
- Holds completed vectors in a small output FIFO and hands them to the software side over a valid/ready handshake; the software side pops them through its DPI shim.
- Compensates for DUT pipeline latency by delaying the stimulus strobe internally.

Parameters:
- TOTAL_WIDTH, 256, collected vector width in bits; must be a multiple of 8.
- NBYTES, TOTAL_WIDTH/8, bytes per vector (derived; not overridden).
- DUT_LATENCY, 1, cycles from stimulus byte accepted to matching res_i valid; range 0..8.
- FIFO_DEPTH, 2, completed-vector output buffer entries; power of two, ≥2.

Ports:
- clk_i  input  1  single clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset: assertion takes effect immediately; deassertion is used synchronously.
- res_i  input  8  DUT result byte.
- in_valid_i  input  1  stimulus BFM presented a byte to the DUT this cycle.
- flush_i  input  1  single-cycle pulse; push a partial vector.
- vec_ready_i  input  1  software side accepts the head vector.
- vec_valid_o  output  1  FIFO non-empty.
- vec_data_o  output  TOTAL_WIDTH  head vector.
- vec_len_o  output  6  valid byte count of the head vector, 1..NBYTES; 32 encoded as 32.
- byte_cnt_o  output  6  bytes collected into the current partial vector.
- overflow_o  output  1  sticky: a completed vector was dropped.

Behaviour:
- Reset (reset_i=0), asynchronous:
  - Outputs: vec_valid_o=0, vec_data_o=0, vec_len_o=0, byte_cnt_o=0, overflow_o=0.
  - Internal state: delay line, accumulator and FIFO pointers cleared.
  - A partial vector in progress at reset is discarded.
- Delay line:
  - sample_en = in_valid_i delayed by DUT_LATENCY registers.
  - DUT_LATENCY=0 means sample_en = in_valid_i combinationally.
  - Gaps in in_valid_i are preserved cycle-exact.
- Accumulate: on sample_en, acc[8*cnt +: 8] <= res_i and cnt <= cnt+1.
  - Byte k of a vector always lands in bits [8k+7:8k].
- Completion: when sample_en occurs with cnt==NBYTES-1:
  - push {res_i, acc[TOTAL_WIDTH-9:0]} with len=NBYTES;
  - cnt <= 0;
  - acc cleared the same cycle.
- Flush: flush_i with cnt>0:
  - push acc with len=cnt; upper bytes are zero;
  - cnt <= 0.
  - flush_i with cnt==0 is a no-op.
  - flush_i coinciding with sample_en: the sample is written first.
    - If that sample completes the vector, only the normal push occurs.
    - Otherwise the pushed partial includes the sample, with len=cnt+1.
- FIFO:
  - Push is registered; a pushed vector is visible on vec_valid_o/vec_data_o the cycle after the push cycle.
  - Pop when vec_valid_o && vec_ready_i; the next entry appears the following cycle.
  - vec_data_o and vec_len_o are stable while vec_valid_o=1 and vec_ready_i=0.
  - When empty, vec_data_o and vec_len_o hold their last value.
  - Push while full with a same-cycle pop: accepted; occupancy unchanged.
  - Push while full without a pop: the vector is dropped, overflow_o <= 1 until reset, and FIFO contents are unchanged.
- byte_cnt_o = cnt, registered, range 0..NBYTES-1.
- Steady-state throughput: one byte per cycle, no bubbles; a new vector may start in the cycle after completion.

Test Plan:
1. Full vector:
   - Stimulus: DUT_LATENCY=1, in_valid_i high cycles 0..31, res_i = 0x01..0x20 in cycles 1..32, ready=1.
   - Response: vec_valid_o=1 at cycle 33 for one cycle, vec_data_o=0x201F1E…030201, vec_len_o=32, byte_cnt_o=0 at cycle 33.
2. Gapped input:
   - Stimulus: in_valid_i alternates 1/0 for 64 cycles; res_i = 2*i for sample i.
   - Response: vector completes after the 32nd sample; byte 5 = 0x0A; no extra bytes captured on gap cycles.
3. Backpressure/overflow:
   - Stimulus: vec_ready_i=0, three back-to-back full vectors.
   - Response: first two retained in order; third dropped; overflow_o=1 from the cycle after the third completion; raising ready then yields vectors 1 and 2 only.
4. Flush:
   - Stimulus: 5 bytes 0xA1..0xA5, then flush_i.
   - Response: vec_data_o=0x…00A5A4A3A2A1 (upper 216 bits zero), vec_len_o=5, byte_cnt_o=0. A second flush with cnt=0 pushes nothing.
5. Simultaneous events:
   - Stimulus: FIFO full and ready=1 while a vector completes in the same cycle.
   - Response: pop and push both occur, overflow_o stays 0, order is preserved.
   - Stimulus: flush_i on the 32nd sample.
   - Response: exactly one 32-byte push.
6. Reset mid-operation:
   - Stimulus: assert reset_i low asynchronously after 17 bytes, with one vector queued.
   - Response: all outputs 0 immediately. After release, 32 new bytes produce exactly one vector containing only the new bytes.

Source files
------------

// File: rtl/bfm_collector.sv
// bfm_collector: receive-side collector for the byte-streaming stimulus BFM.
// Samples the DUT result byte once per accepted stimulus byte, after a fixed
// pipeline delay. It packs NBYTES bytes LSB-first into a TOTAL_WIDTH vector and
// queues completed vectors in a small FIFO with a valid/ready output.
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-low reset
//   res_i        DUT result byte
//   in_valid_i   stimulus byte accepted by the DUT this cycle
//   flush_i      push the current partial vector (pulse)
//   vec_ready_i  consumer accepts the head vector
//   vec_valid_o  FIFO non-empty
//   vec_data_o   head vector (holds last value when empty)
//   vec_len_o    valid byte count of the head vector
//   byte_cnt_o   bytes collected into the current partial vector
//   overflow_o   sticky: a completed vector was dropped
module bfm_collector #(
    parameter int unsigned TOTAL_WIDTH = 256,
    parameter int unsigned DUT_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [7:0]             res_i,
    input  logic                   in_valid_i,
    input  logic                   flush_i,
    input  logic                   vec_ready_i,
    output logic                   vec_valid_o,
    output logic [TOTAL_WIDTH-1:0] vec_data_o,
    output logic [5:0]             vec_len_o,
    output logic [5:0]             byte_cnt_o,
    output logic                   overflow_o
);

    localparam int unsigned NBYTES = TOTAL_WIDTH / 8;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W  = PTR_W + 1;

    logic sample_en;

    // Delay line: in_valid_i delayed by DUT_LATENCY cycles, gaps preserved.
    if (DUT_LATENCY == 0) begin : g_nodly
        assign sample_en = in_valid_i;
    end else begin : g_dly
        logic [DUT_LATENCY-1:0] dly_q;
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= in_valid_i;
                for (int i = 1; i < int'(DUT_LATENCY); i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end
        assign sample_en = dly_q[DUT_LATENCY-1];
    end

    // Accumulator state
    logic [TOTAL_WIDTH-1:0] acc_q, acc_d, acc_w;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   push_c;
    logic [CNT_W-1:0]       push_len_c;

    // Byte insertion, completion and flush. acc_w already contains this
    // cycle's sample, so a flush coinciding with a sample includes it.
    always_comb begin
        acc_w = acc_q;
        if (sample_en) begin
            for (int k = 0; k < int'(NBYTES); k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    acc_w[8*k +: 8] = res_i;
                end
            end
        end
        cnt_inc    = sample_en ? (cnt_q + CNT_W'(1)) : cnt_q;
        push_c     = 1'b0;
        push_len_c = cnt_inc;
        acc_d      = acc_w;
        cnt_d      = cnt_inc;
        if (sample_en && (cnt_q == CNT_W'(NBYTES - 1))) begin
            push_c     = 1'b1;
            push_len_c = CNT_W'(NBYTES);
            acc_d      = '0;
            cnt_d      = '0;
        end else if (flush_i && (cnt_inc != '0)) begin
            push_c = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign byte_cnt_o = cnt_q;

    // Output FIFO
    logic [TOTAL_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [CNT_W-1:0]       mem_len_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   do_pop, do_push, drop, full;
    logic                   vec_valid_d;
    logic [TOTAL_WIDTH-1:0] vec_data_d;
    logic [CNT_W-1:0]       vec_len_d;

    // Pointer/occupancy update and look-ahead of the next head entry, so the
    // head registers are loaded in the same edge as the push or pop.
    always_comb begin
        do_pop   = vec_valid_o && vec_ready_i;
        full     = (occ_q == OCC_W'(FIFO_DEPTH));
        do_push  = push_c && (!full || do_pop);
        drop     = push_c && full && !do_pop;
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        occ_d    = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        vec_valid_d = (occ_d != '0);
        vec_data_d  = vec_data_o;
        vec_len_d   = vec_len_o;
        if (vec_valid_d) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                vec_data_d = acc_w;
                vec_len_d  = push_len_c;
            end else begin
                vec_data_d = mem_data_q[rd_ptr_d];
                vec_len_d  = mem_len_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_data_q[i] <= '0;
                mem_len_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            vec_valid_o <= 1'b0;
            vec_data_o  <= '0;
            vec_len_o   <= '0;
            overflow_o  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_data_q[wr_ptr_q] <= acc_w;
                mem_len_q[wr_ptr_q]  <= push_len_c;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            vec_valid_o <= vec_valid_d;
            vec_data_o  <= vec_data_d;
            vec_len_o   <= vec_len_d;
            overflow_o  <= overflow_o | drop;
        end
    end

endmodule
